cam_pwr_seq: RTL and testbench
==============================

Name: cam_pwr_seq

Overview:
- Tick-driven power-up/reset sequencer for the CMOS camera and the I2C master.
- Consumes the 400kHz strobe from clock/reset generation and drives cam_en, pwd and i2c_areset_n through a programmable sequence.
- Waits for the I2C init handshake and retries with a full power cycle on error or timeout.
- Reports ready or fault status to top level and LEDs; replaces the fixed 1Hz-counter sequencing with a parameterised FSM.

Parameters:
- T_OFF_TICKS, 400000, power-off dwell in ticks (1s at 400kHz)
- T_PWR_TICKS, 800000, cam_en-on settle time before the pwd pulse (2s)
- T_PWD_TICKS, 400000, duration of each pwd low and pwd high phase (1s)
- T_I2C_TICKS, 400000, delay from final pwd deassert to I2C reset release (1s)
- T_INIT_TO_TICKS, 4000000, i2c_init_done timeout (10s)
- MAX_RETRY, 3, power-cycle retries before FAULT (range 0..3)

Ports:
- clk  in  1  system clock (100MHz domain)
- reset  in  1  asynchronous, active-high reset
- tick  in  1  one-clk strobe (strobe_400kHz), synchronous to clk
- restart_req  in  1  one-clk pulse: restart sequence from OFF, clear fault/retries
- i2c_init_done  in  1  level/pulse from I2C master: camera init complete
- i2c_init_err  in  1  level/pulse from I2C master: NACK or init failure
- cam_en  out  1  camera supply enable
- pwd  out  1  camera power-down, 1 = powered down
- i2c_areset_n  out  1  I2C master reset, active-low
- seq_ready  out  1  sequence complete, camera initialised
- seq_fault  out  1  retries exhausted, sticky
- retry_cnt  out  2  retries consumed in the current attempt
- seq_state  out  3  encoded FSM state (debug/ILA)

Behaviour:
- Reset values: cam_en=0, pwd=1, i2c_areset_n=0, seq_ready=0, seq_fault=0, retry_cnt=0, seq_state=OFF, dwell counter=0.
- All outputs are registered, decoded from the next state, and change on the same clk edge as the state change.
- Dwell counter is TICK_CNT_W bits. It increments only on tick. In a timed state, the transition fires on the tick where cnt == T-1; cnt clears to 0 on every state change.
- States, with outputs cam_en/pwd/i2c_areset_n:
  - OFF (0/1/0): after T_OFF_TICKS -> PWR.
  - PWR (1/1/0): after T_PWR_TICKS -> PWD_LO.
  - PWD_LO (1/0/0): after T_PWD_TICKS -> PWD_HI.
  - PWD_HI (1/1/0): after T_PWD_TICKS -> WAKE.
  - WAKE (1/0/0): after T_I2C_TICKS -> INIT.
  - INIT (1/0/1): handshake inputs are sampled every clk, not tick-gated.
    - i2c_init_done -> READY.
    - i2c_init_err, or cnt == T_INIT_TO_TICKS-1 on a tick -> FAIL path.
  - READY (1/0/1): seq_ready=1; hold until restart_req. Later done/err inputs are ignored.
  - FAULT (0/1/0): seq_fault=1; hold until restart_req.
- FAIL path:
  - if retry_cnt < MAX_RETRY: retry_cnt++, -> OFF.
  - else -> FAULT; retry_cnt holds its value.
- Priority within one cycle: restart_req > i2c_init_err > timeout > i2c_init_done. Done and err together counts as a failure.
- restart_req in any state: -> OFF, cnt=0, retry_cnt=0, seq_fault=0, seq_ready=0, and outputs forced to the OFF values on the next edge.
- Asserting reset mid-sequence forces the reset values immediately (asynchronous). No partial-state recovery.
- T values of 1 are legal: the state lasts exactly one tick. A tick coinciding with restart_req is consumed by the restart.
- No combinational path from inputs to outputs.

Decomposition:
- top_pkg: TICK_CNT_W=23 (fits 4000000); typedef tick_cnt_t; typedef enum logic[2:0] seq_state_t {OFF, PWR, PWD_LO, PWD_HI, WAKE, INIT, READY, FAULT}; default timing constants derived from NUM_CLK_FOR_400kHZ.
- Sub-module tick_timer: tick-gated dwell counter with load/clear, input terminal count, output expire pulse.
- Parent keeps the FSM, retry logic and output registers.

Test Plan:
- Bench setup: T_OFF=2, T_PWR=4, T_PWD=3, T_I2C=2, T_INIT_TO=10, MAX_RETRY=2, tick every 4 clk.
- Nominal: release reset, pulse done 5 ticks into INIT -> pwd transitions 1->0 at tick 6, 0->1 at tick 9, 1->0 at tick 12; i2c_areset_n=1 at tick 14; seq_ready=1 one clk after done; retry_cnt=0.
- Timeout: never assert done -> 10 ticks in INIT, then OFF with retry_cnt=1; after 2 retries -> FAULT with seq_fault=1, cam_en=0, pwd=1, retry_cnt=2.
- Error then success: pulse err in INIT on attempt 0, then done on attempt 1 -> READY with retry_cnt=1.
- Simultaneous events: done and err in the same clk -> failure path, retry_cnt increments. restart_req together with done -> OFF, seq_ready stays 0.
- Restart from FAULT/READY: pulse restart_req -> next edge seq_fault=0, seq_ready=0, retry_cnt=0, state OFF; full nominal sequence repeats.
- Reset mid-PWD_LO: assert reset asynchronously between clk edges -> outputs take reset values immediately; after release, OFF dwell restarts from cnt=0.

Source files
------------

// File: rtl/cam_pwr_seq_pkg.sv
// Shared types and default timing for the camera/I2C power-up sequencer.
package cam_pwr_seq_pkg;

    localparam int CLK_HZ             = 100_000_000;
    localparam int NUM_CLK_FOR_400kHZ = CLK_HZ / 400_000;
    localparam int TICKS_PER_SEC      = CLK_HZ / NUM_CLK_FOR_400kHZ;

    localparam int DEF_T_OFF_TICKS     = TICKS_PER_SEC;
    localparam int DEF_T_PWR_TICKS     = 2 * TICKS_PER_SEC;
    localparam int DEF_T_PWD_TICKS     = TICKS_PER_SEC;
    localparam int DEF_T_I2C_TICKS     = TICKS_PER_SEC;
    localparam int DEF_T_INIT_TO_TICKS = 10 * TICKS_PER_SEC;
    localparam int DEF_MAX_RETRY       = 3;

    localparam int TICK_CNT_W = 23;
    typedef logic [TICK_CNT_W-1:0] tick_cnt_t;

    typedef enum logic [2:0] {
        OFF    = 3'd0,
        PWR    = 3'd1,
        PWD_LO = 3'd2,
        PWD_HI = 3'd3,
        WAKE   = 3'd4,
        INIT   = 3'd5,
        READY  = 3'd6,
        FAULT  = 3'd7
    } seq_state_t;

    typedef struct packed {
        logic cam_en;
        logic pwd;
        logic i2c_areset_n;
    } pwr_drive_t;

    // Pin levels the camera and I2C master see while the FSM sits in a state.
    function automatic pwr_drive_t state_drive(input seq_state_t s);
        pwr_drive_t d;
        case (s)
            PWR, PWD_HI:  d = '{cam_en: 1'b1, pwd: 1'b1, i2c_areset_n: 1'b0};
            PWD_LO, WAKE: d = '{cam_en: 1'b1, pwd: 1'b0, i2c_areset_n: 1'b0};
            INIT, READY:  d = '{cam_en: 1'b1, pwd: 1'b0, i2c_areset_n: 1'b1};
            default:      d = '{cam_en: 1'b0, pwd: 1'b1, i2c_areset_n: 1'b0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cam_pwr_seq_if.sv
// Control/status bundle between the sequencer and its surroundings.
interface cam_pwr_seq_if;
    import cam_pwr_seq_pkg::*;

    logic       tick;
    logic       restart_req;
    logic       i2c_init_done;
    logic       i2c_init_err;
    logic       cam_en;
    logic       pwd;
    logic       i2c_areset_n;
    logic       seq_ready;
    logic       seq_fault;
    logic [1:0] retry_cnt;
    logic [2:0] seq_state;

    modport slave (
        input  tick, restart_req, i2c_init_done, i2c_init_err,
        output cam_en, pwd, i2c_areset_n, seq_ready, seq_fault, retry_cnt, seq_state
    );

    modport master (
        output tick, restart_req, i2c_init_done, i2c_init_err,
        input  cam_en, pwd, i2c_areset_n, seq_ready, seq_fault, retry_cnt, seq_state
    );
endinterface

// File: rtl/cam_pwr_seq_tick_timer.sv
// Tick-gated dwell counter; expire_o pulses on the tick that completes the dwell.
module cam_pwr_seq_tick_timer
    import cam_pwr_seq_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      tick_i,
    input  logic      clear_i,
    input  tick_cnt_t last_i,
    output logic      expire_o
);

    tick_cnt_t cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (tick_i) begin
            cnt_d = cnt_q + tick_cnt_t'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = tick_i && (cnt_q == last_i);

endmodule

// File: rtl/cam_pwr_seq.sv
// Camera supply / power-down / I2C-reset sequencer with retry-on-failure.
module cam_pwr_seq
    import cam_pwr_seq_pkg::*;
#(
    parameter int T_OFF_TICKS     = DEF_T_OFF_TICKS,
    parameter int T_PWR_TICKS     = DEF_T_PWR_TICKS,
    parameter int T_PWD_TICKS     = DEF_T_PWD_TICKS,
    parameter int T_I2C_TICKS     = DEF_T_I2C_TICKS,
    parameter int T_INIT_TO_TICKS = DEF_T_INIT_TO_TICKS,
    parameter int MAX_RETRY       = DEF_MAX_RETRY
) (
    input  logic           clk,
    input  logic           reset,
    cam_pwr_seq_if.slave   bus
);

    localparam tick_cnt_t OFF_LAST  = tick_cnt_t'(T_OFF_TICKS - 1);
    localparam tick_cnt_t PWR_LAST  = tick_cnt_t'(T_PWR_TICKS - 1);
    localparam tick_cnt_t PWD_LAST  = tick_cnt_t'(T_PWD_TICKS - 1);
    localparam tick_cnt_t I2C_LAST  = tick_cnt_t'(T_I2C_TICKS - 1);
    localparam tick_cnt_t INIT_LAST = tick_cnt_t'(T_INIT_TO_TICKS - 1);

    seq_state_t state_q, state_d;
    logic [1:0] retry_q, retry_d;
    pwr_drive_t drive_q, drive_d;
    logic       ready_q, fault_q;

    tick_cnt_t  dwell_last;
    logic       expire;
    logic       timer_clear;

    always_comb begin
        dwell_last = OFF_LAST;
        case (state_q)
            PWR:           dwell_last = PWR_LAST;
            PWD_LO, PWD_HI: dwell_last = PWD_LAST;
            WAKE:          dwell_last = I2C_LAST;
            INIT:          dwell_last = INIT_LAST;
            default:       dwell_last = OFF_LAST;
        endcase
    end

    // Restart must clear the count even when already sitting in OFF.
    assign timer_clear = (state_d != state_q) || bus.restart_req;

    cam_pwr_seq_tick_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .tick_i   (bus.tick),
        .clear_i  (timer_clear),
        .last_i   (dwell_last),
        .expire_o (expire)
    );

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        if (bus.restart_req) begin
            state_d = OFF;
            retry_d = 2'd0;
        end else begin
            case (state_q)
                OFF:    if (expire) state_d = PWR;
                PWR:    if (expire) state_d = PWD_LO;
                PWD_LO: if (expire) state_d = PWD_HI;
                PWD_HI: if (expire) state_d = WAKE;
                WAKE:   if (expire) state_d = INIT;
                INIT: begin
                    // A simultaneous done and err is treated as a failure.
                    if (bus.i2c_init_err || expire) begin
                        if (int'(retry_q) < MAX_RETRY) begin
                            retry_d = retry_q + 2'd1;
                            state_d = OFF;
                        end else begin
                            state_d = FAULT;
                        end
                    end else if (bus.i2c_init_done) begin
                        state_d = READY;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    assign drive_d = state_drive(state_d);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= OFF;
            retry_q <= 2'd0;
            drive_q <= '{cam_en: 1'b0, pwd: 1'b1, i2c_areset_n: 1'b0};
            ready_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            drive_q <= drive_d;
            ready_q <= (state_d == READY);
            fault_q <= (state_d == FAULT);
        end
    end

    assign bus.cam_en       = drive_q.cam_en;
    assign bus.pwd          = drive_q.pwd;
    assign bus.i2c_areset_n = drive_q.i2c_areset_n;
    assign bus.seq_ready    = ready_q;
    assign bus.seq_fault    = fault_q;
    assign bus.retry_cnt    = retry_q;
    assign bus.seq_state    = state_q;

endmodule

// File: tb/tb_cam_pwr_seq.sv
// Directed bench: vector table of tick runs plus pulses, then restart/reset corner cases.
module tb_cam_pwr_seq;
    import cam_pwr_seq_pkg::*;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    cam_pwr_seq_if bus();

    cam_pwr_seq #(
        .T_OFF_TICKS     (2),
        .T_PWR_TICKS     (4),
        .T_PWD_TICKS     (3),
        .T_I2C_TICKS     (2),
        .T_INIT_TO_TICKS (10),
        .MAX_RETRY       (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         ticks;
        logic       done;
        logic       err;
        logic       rst_req;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [9:0] pk(input logic ce, input logic pw, input logic ar,
                                      input logic rdy, input logic flt,
                                      input logic [1:0] rc, input logic [2:0] st);
        return {ce, pw, ar, rdy, flt, rc, st};
    endfunction

    task automatic add(input int t, input logic d, input logic e, input logic r,
                       input logic [9:0] x);
        vec_t v;
        v.ticks = t; v.done = d; v.err = e; v.rst_req = r; v.exp = x;
        vecs.push_back(v);
    endtask

    function automatic logic [9:0] observed();
        return {bus.cam_en, bus.pwd, bus.i2c_areset_n, bus.seq_ready, bus.seq_fault,
                bus.retry_cnt, bus.seq_state};
    endfunction

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got ce/pwd/ar/rdy/flt/rc/st=%b expected %b", name, act, exp);
        end else begin
            $display("ok   %s: %b", name, act);
        end
    endtask

    // Called at a negedge: drive inputs, let one posedge pass, return at the next negedge.
    task automatic cyc(input logic t, input logic r, input logic d, input logic e);
        bus.tick = t; bus.restart_req = r; bus.i2c_init_done = d; bus.i2c_init_err = e;
        @(negedge clk);
        bus.tick = 1'b0; bus.restart_req = 1'b0; bus.i2c_init_done = 1'b0; bus.i2c_init_err = 1'b0;
    endtask

    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) begin
            repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        bus.tick = 1'b0; bus.restart_req = 1'b0;
        bus.i2c_init_done = 1'b0; bus.i2c_init_err = 1'b0;

        // Nominal power-up, done 5 ticks into INIT, late inputs ignored, restart.
        add(1,  0,0,0, pk(0,1,0,0,0,2'd0,3'd0));
        add(1,  0,0,0, pk(1,1,0,0,0,2'd0,3'd1));
        add(3,  0,0,0, pk(1,1,0,0,0,2'd0,3'd1));
        add(1,  0,0,0, pk(1,0,0,0,0,2'd0,3'd2));
        add(2,  0,0,0, pk(1,0,0,0,0,2'd0,3'd2));
        add(1,  0,0,0, pk(1,1,0,0,0,2'd0,3'd3));
        add(3,  0,0,0, pk(1,0,0,0,0,2'd0,3'd4));
        add(1,  0,0,0, pk(1,0,0,0,0,2'd0,3'd4));
        add(1,  0,0,0, pk(1,0,1,0,0,2'd0,3'd5));
        add(5,  1,0,0, pk(1,0,1,1,0,2'd0,3'd6));
        add(20, 0,1,0, pk(1,0,1,1,0,2'd0,3'd6));
        add(0,  0,0,1, pk(0,1,0,0,0,2'd0,3'd0));
        // Timeouts until FAULT, then restart.
        add(14, 0,0,0, pk(1,0,1,0,0,2'd0,3'd5));
        add(9,  0,0,0, pk(1,0,1,0,0,2'd0,3'd5));
        add(1,  0,0,0, pk(0,1,0,0,0,2'd1,3'd0));
        add(14, 0,0,0, pk(1,0,1,0,0,2'd1,3'd5));
        add(10, 0,0,0, pk(0,1,0,0,0,2'd2,3'd0));
        add(14, 0,0,0, pk(1,0,1,0,0,2'd2,3'd5));
        add(10, 0,0,0, pk(0,1,0,0,1,2'd2,3'd7));
        add(5,  1,0,0, pk(0,1,0,0,1,2'd2,3'd7));
        add(0,  0,0,1, pk(0,1,0,0,0,2'd0,3'd0));
        // Error then success.
        add(14, 0,1,0, pk(0,1,0,0,0,2'd1,3'd0));
        add(14, 1,0,0, pk(1,0,1,1,0,2'd1,3'd6));
        add(0,  0,0,1, pk(0,1,0,0,0,2'd0,3'd0));
        // Simultaneous events.
        add(14, 1,1,0, pk(0,1,0,0,0,2'd1,3'd0));
        add(14, 1,0,1, pk(0,1,0,0,0,2'd0,3'd0));

        repeat (2) @(negedge clk);
        check("reset_state", observed(), pk(0,1,0,0,0,2'd0,3'd0));
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            tick_n(vecs[i].ticks);
            if (vecs[i].done || vecs[i].err || vecs[i].rst_req)
                cyc(1'b0, vecs[i].rst_req, vecs[i].done, vecs[i].err);
            check($sformatf("vec%0d", i), observed(), vecs[i].exp);
        end

        // Tick coinciding with restart is consumed: OFF needs two further ticks.
        tick_n(1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check("restart_tick_off", observed(), pk(0,1,0,0,0,2'd0,3'd0));
        tick_n(1);
        check("restart_tick_still_off", observed(), pk(0,1,0,0,0,2'd0,3'd0));
        tick_n(1);
        check("restart_tick_pwr", observed(), pk(1,1,0,0,0,2'd0,3'd1));

        // Asynchronous reset in PWD_LO, applied between clock edges.
        tick_n(5);
        check("pre_reset_pwd_lo", observed(), pk(1,0,0,0,0,2'd0,3'd2));
        #2 reset = 1'b1;
        #1 check("async_reset_now", observed(), pk(0,1,0,0,0,2'd0,3'd0));
        @(negedge clk);
        reset = 1'b0;
        tick_n(1);
        check("post_reset_off", observed(), pk(0,1,0,0,0,2'd0,3'd0));
        tick_n(1);
        check("post_reset_pwr", observed(), pk(1,1,0,0,0,2'd0,3'd1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
